// File: rtl/mem_read_sweeper.sv
// Sweeps a synchronous-read memory once per start edge, holding each address
// HOLD_CYCLES clocks and strobing every captured word out in address order.
module mem_read_sweeper #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              read_done
);

  localparam logic [15:0]       HC_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                start_q;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [15:0]         hc_q, hc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic trigger;
  logic hold_end;
  logic last_addr;

  assign trigger   = start & ~start_q;
  assign hold_end  = (hc_q == HC_LAST);
  assign last_addr = (rd_addr_q == ADDR_LAST);

  // State and datapath registers; reset also clears the edge detector so a
  // start held through reset fires on the first post-reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      rd_addr_q <= '0;
      hc_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      rd_addr_q <= rd_addr_d;
      hc_q      <= hc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (trigger) state_d = S_READ;
      S_READ: if (hold_end && last_addr) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    hc_d      = hc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          rd_addr_d = '0;
          hc_d      = '0;
          busy_d    = 1'b1;
        end
      end
      S_READ: begin
        if (hold_end) begin
          // Address has been stable for HOLD_CYCLES clocks, so rd_data is settled.
          hc_d    = '0;
          data_d  = rd_data;
          valid_d = 1'b1;
          if (last_addr) begin
            rd_addr_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
          end
        end else begin
          hc_d = hc_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign rd_addr    = rd_addr_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign read_done  = done_q;

endmodule
